// File: rtl/sprite_motion_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sprite_motion_ctrl_pkg
// Shared definitions for the sprite pipeline (motion, renderer, collision,
// score): screen geometry, sprite size and the motion state encoding.
// -----------------------------------------------------------------------------
package sprite_motion_ctrl_pkg;

   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;
   localparam int SPRITE_SIZE = 16;
   localparam int POS_W       = 10;

   typedef enum logic [1:0] {
      ST_ALIVE = 2'd0,
      ST_HIT   = 2'd1,
      ST_DEAD  = 2'd2
   } motion_state_e;

endpackage

// File: rtl/sprite_motion_ctrl_axis_stepper.sv
// -----------------------------------------------------------------------------
// sprite_motion_ctrl_axis_stepper
// Computes the next position on one axis from the current position and the
// two opposing direction buttons, clamped to [0, max].
// Ports:
//   pos  - current position
//   dec  - move toward 0 (left / up)
//   inc  - move toward max (right / down)
//   step - pixels per move
//   max  - largest legal position
//   nxt  - clamped next position (equals pos when both or neither pressed)
// -----------------------------------------------------------------------------
module sprite_motion_ctrl_axis_stepper
   import sprite_motion_ctrl_pkg::*;
(
   input  logic [POS_W-1:0] pos,
   input  logic             dec,
   input  logic             inc,
   input  logic [3:0]       step,
   input  logic [POS_W-1:0] max,
   output logic [POS_W-1:0] nxt
);

   logic [POS_W:0]   sum_s;
   logic [POS_W-1:0] step_ext_s;

   // Clamped step: the sum carries one extra bit so overflow past max is seen.
   always_comb begin
      step_ext_s = {6'd0, step};
      sum_s      = {1'b0, pos} + {7'd0, step};
      if (dec && !inc) begin
         nxt = (pos < step_ext_s) ? 10'd0 : (pos - step_ext_s);
      end else if (inc && !dec) begin
         nxt = (sum_s > {1'b0, max}) ? max : sum_s[POS_W-1:0];
      end else begin
         nxt = pos;
      end
   end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_motion_ctrl
// Owns the player sprite position, visibility and lives. Position moves once
// per frame from the buttons; a collision pulse costs a life and opens a
// blinking invulnerability window, or ends the game on the last life.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   frame_tick               - one-cycle pulse at start of vertical blanking
//   btn_left/right/up/down   - debounced button levels
//   hit                      - one-cycle collision pulse
//   sprite_x, sprite_y       - registered top-left position
//   visible                  - registered sprite enable for the pixel mux
//   lives                    - registered remaining lives
//   game_over                - registered, high once all lives are gone
// -----------------------------------------------------------------------------
module sprite_motion_ctrl
   import sprite_motion_ctrl_pkg::*;
#(
   parameter logic [POS_W-1:0] START_X      = 10'd312,
   parameter logic [POS_W-1:0] START_Y      = 10'd440,
   parameter logic [3:0]       STEP         = 4'd2,
   parameter logic [POS_W-1:0] MAX_X        = POS_W'(SCREEN_W - SPRITE_SIZE),
   parameter logic [POS_W-1:0] MAX_Y        = POS_W'(SCREEN_H - SPRITE_SIZE),
   parameter logic [1:0]       LIVES        = 2'd3,
   parameter logic [7:0]       HIT_FRAMES   = 8'd60,
   parameter logic [3:0]       BLINK_FRAMES = 4'd4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_tick,
   input  logic             btn_left,
   input  logic             btn_right,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             hit,
   output logic [POS_W-1:0] sprite_x,
   output logic [POS_W-1:0] sprite_y,
   output logic             visible,
   output logic [1:0]       lives,
   output logic             game_over
);

   motion_state_e    state_r, state_nxt_s;
   logic [POS_W-1:0] x_r, y_r, x_nxt_s, y_nxt_s, x_step_s, y_step_s;
   logic             visible_r, visible_nxt_s;
   logic [1:0]       lives_r, lives_nxt_s;
   logic             game_over_r, game_over_nxt_s;
   logic [7:0]       hit_cnt_r, hit_cnt_nxt_s;
   logic [3:0]       blink_cnt_r, blink_cnt_nxt_s;
   logic             move_s;

   sprite_motion_ctrl_axis_stepper u_step_x (
      .pos  (x_r),
      .dec  (btn_left),
      .inc  (btn_right),
      .step (STEP),
      .max  (MAX_X),
      .nxt  (x_step_s)
   );

   sprite_motion_ctrl_axis_stepper u_step_y (
      .pos  (y_r),
      .dec  (btn_up),
      .inc  (btn_down),
      .step (STEP),
      .max  (MAX_Y),
      .nxt  (y_step_s)
   );

   // Next-state logic: life loss, invulnerability window, blink and movement.
   always_comb begin
      state_nxt_s     = state_r;
      visible_nxt_s   = visible_r;
      lives_nxt_s     = lives_r;
      game_over_nxt_s = game_over_r;
      hit_cnt_nxt_s   = hit_cnt_r;
      blink_cnt_nxt_s = blink_cnt_r;
      move_s          = 1'b0;
      case (state_r)
         ST_ALIVE: begin
            move_s = frame_tick;
            if (hit) begin
               lives_nxt_s   = lives_r - 2'd1;
               visible_nxt_s = 1'b0;
               if (lives_r == 2'd1) begin
                  // The last life freezes the sprite even if a tick coincides.
                  state_nxt_s     = ST_DEAD;
                  game_over_nxt_s = 1'b1;
                  move_s          = 1'b0;
               end else begin
                  state_nxt_s     = ST_HIT;
                  hit_cnt_nxt_s   = HIT_FRAMES;
                  blink_cnt_nxt_s = 4'd0;
               end
            end else begin
               visible_nxt_s = 1'b1;
            end
         end
         ST_HIT: begin
            move_s = frame_tick;
            if (frame_tick) begin
               hit_cnt_nxt_s = hit_cnt_r - 8'd1;
               if (hit_cnt_r == 8'd1) begin
                  state_nxt_s     = ST_ALIVE;
                  visible_nxt_s   = 1'b1;
                  blink_cnt_nxt_s = 4'd0;
               end else if ((blink_cnt_r + 4'd1) == BLINK_FRAMES) begin
                  blink_cnt_nxt_s = 4'd0;
                  visible_nxt_s   = ~visible_r;
               end else begin
                  blink_cnt_nxt_s = blink_cnt_r + 4'd1;
               end
            end else begin
               hit_cnt_nxt_s = hit_cnt_r;
            end
         end
         ST_DEAD: begin
            visible_nxt_s   = 1'b0;
            game_over_nxt_s = 1'b1;
         end
         default: begin
            // Unused encoding: fail safe into the frozen game-over state.
            state_nxt_s     = ST_DEAD;
            visible_nxt_s   = 1'b0;
            game_over_nxt_s = 1'b1;
         end
      endcase
      x_nxt_s = move_s ? x_step_s : x_r;
      y_nxt_s = move_s ? y_step_s : y_r;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_ALIVE;
         x_r         <= START_X;
         y_r         <= START_Y;
         visible_r   <= 1'b1;
         lives_r     <= LIVES;
         game_over_r <= 1'b0;
         hit_cnt_r   <= 8'd0;
         blink_cnt_r <= 4'd0;
      end else begin
         state_r     <= state_nxt_s;
         x_r         <= x_nxt_s;
         y_r         <= y_nxt_s;
         visible_r   <= visible_nxt_s;
         lives_r     <= lives_nxt_s;
         game_over_r <= game_over_nxt_s;
         hit_cnt_r   <= hit_cnt_nxt_s;
         blink_cnt_r <= blink_cnt_nxt_s;
      end
   end

   assign sprite_x  = x_r;
   assign sprite_y  = y_r;
   assign visible   = visible_r;
   assign lives     = lives_r;
   assign game_over = game_over_r;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_motion_ctrl
// Bench for sprite_motion_ctrl: a vector table for basic movement, directly
// exercised axis stepper clamp cases, and hand-written sequences for clamping
// walks, the hit/blink window, game over, coincident hit+tick and mid-HIT reset.
// -----------------------------------------------------------------------------
module tb_sprite_motion_ctrl;

   logic       clk = 1'b0;
   logic       rst, frame_tick, btn_left, btn_right, btn_up, btn_down, hit;
   logic [9:0] sprite_x, sprite_y;
   logic       visible, game_over;
   logic [1:0] lives;

   logic [9:0] st_pos, st_max, st_nxt;
   logic       st_dec, st_inc;
   logic [3:0] st_step;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       tick, l, r, u, d, h, rs;
      logic [9:0] x, y;
      logic       vis;
      logic [1:0] lv;
      logic       go;
   } vec_t;

   typedef struct {
      logic [9:0] x, y;
      logic       vis;
      logic [1:0] lv;
      logic       go;
   } exp_t;

   typedef struct {
      logic [9:0] pos;
      logic       dec, inc;
      logic [3:0] step;
      logic [9:0] mx, nxt;
   } svec_t;

   exp_t exp_q[$];

   sprite_motion_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .hit        (hit),
      .sprite_x   (sprite_x),
      .sprite_y   (sprite_y),
      .visible    (visible),
      .lives      (lives),
      .game_over  (game_over)
   );

   sprite_motion_ctrl_axis_stepper u_stepper (
      .pos  (st_pos),
      .dec  (st_dec),
      .inc  (st_inc),
      .step (st_step),
      .max  (st_max),
      .nxt  (st_nxt)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic cmp(input string nm, input string fld, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s %s got %0d want %0d", nm, fld, got, want);
      end
   endtask

   // One clock cycle: drive inputs on the falling edge, queue the expectation,
   // then compare just after the rising edge.
   task automatic step(input logic t, l, r, u, d, h, rs,
                       input logic [9:0] ex, ey, input logic ev,
                       input logic [1:0] el, input logic eg, input string nm);
      exp_t e;
      @(negedge clk);
      frame_tick = t; btn_left = l; btn_right = r; btn_up = u; btn_down = d;
      hit = h; rst = rs;
      e.x = ex; e.y = ey; e.vis = ev; e.lv = el; e.go = eg;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard empty", nm);
      end else begin
         e = exp_q.pop_front();
         cmp(nm, "x", int'(sprite_x), int'(e.x));
         cmp(nm, "y", int'(sprite_y), int'(e.y));
         cmp(nm, "visible", int'(visible), int'(e.vis));
         cmp(nm, "lives", int'(lives), int'(e.lv));
         cmp(nm, "game_over", int'(game_over), int'(e.go));
      end
   endtask

   task automatic do_reset(input string nm);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd312, 10'd440, 1'b1, 2'd3, 1'b0, nm);
   endtask

   vec_t  tbl[10];
   svec_t stbl[15];

   initial begin
      int ex, ey, v;
      logic ev;

      // {tick,l,r,u,d,hit,rst, x,y,vis,lives,go}
      tbl[0] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 10'd314,10'd440,1'b1,2'd3,1'b0};
      tbl[1] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 10'd314,10'd440,1'b1,2'd3,1'b0};
      tbl[2] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 10'd316,10'd440,1'b1,2'd3,1'b0};
      tbl[3] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 10'd316,10'd440,1'b1,2'd3,1'b0};
      tbl[4] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 10'd316,10'd440,1'b1,2'd3,1'b0};
      tbl[5] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 10'd316,10'd438,1'b1,2'd3,1'b0};
      tbl[6] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 10'd316,10'd440,1'b1,2'd3,1'b0};
      tbl[7] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 10'd314,10'd440,1'b1,2'd3,1'b0};
      tbl[8] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 10'd314,10'd440,1'b1,2'd3,1'b0};
      tbl[9] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 10'd314,10'd440,1'b1,2'd3,1'b0};

      // {pos, dec, inc, step, max, expected next}
      stbl[0]  = '{10'd1,   1'b1, 1'b0, 4'd2,  10'd624, 10'd0};
      stbl[1]  = '{10'd0,   1'b1, 1'b0, 4'd2,  10'd624, 10'd0};
      stbl[2]  = '{10'd3,   1'b1, 1'b0, 4'd2,  10'd624, 10'd1};
      stbl[3]  = '{10'd2,   1'b1, 1'b0, 4'd2,  10'd624, 10'd0};
      stbl[4]  = '{10'd623, 1'b0, 1'b1, 4'd2,  10'd624, 10'd624};
      stbl[5]  = '{10'd624, 1'b0, 1'b1, 4'd2,  10'd624, 10'd624};
      stbl[6]  = '{10'd622, 1'b0, 1'b1, 4'd2,  10'd624, 10'd624};
      stbl[7]  = '{10'd621, 1'b0, 1'b1, 4'd2,  10'd624, 10'd623};
      stbl[8]  = '{10'd500, 1'b1, 1'b1, 4'd2,  10'd624, 10'd500};
      stbl[9]  = '{10'd10,  1'b1, 1'b0, 4'd15, 10'd624, 10'd0};
      stbl[10] = '{10'd16,  1'b1, 1'b0, 4'd15, 10'd624, 10'd1};
      stbl[11] = '{10'd15,  1'b1, 1'b0, 4'd15, 10'd624, 10'd0};
      stbl[12] = '{10'd610, 1'b0, 1'b1, 4'd15, 10'd624, 10'd624};
      stbl[13] = '{10'd608, 1'b0, 1'b1, 4'd15, 10'd624, 10'd623};
      stbl[14] = '{10'd460, 1'b0, 1'b1, 4'd2,  10'd464, 10'd462};

      rst = 1'b1; frame_tick = 1'b0; hit = 1'b0;
      btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      st_pos = 10'd0; st_dec = 1'b0; st_inc = 1'b0; st_step = 4'd0; st_max = 10'd0;

      do_reset("reset0");
      do_reset("reset1");

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].tick, tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d, tbl[i].h, tbl[i].rs,
              tbl[i].x, tbl[i].y, tbl[i].vis, tbl[i].lv, tbl[i].go, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 15; i++) begin
         st_pos = stbl[i].pos; st_dec = stbl[i].dec; st_inc = stbl[i].inc;
         st_step = stbl[i].step; st_max = stbl[i].mx;
         #1;
         cmp($sformatf("stepper%0d", i), "nxt", int'(st_nxt), int'(stbl[i].nxt));
      end

      // btn_right held for 10 frames; no change between ticks.
      do_reset("reset_right");
      for (int k = 1; k <= 10; k++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'(312 + 2*k), 10'd440, 1'b1, 2'd3, 1'b0, "right_tick");
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'(312 + 2*k), 10'd440, 1'b1, 2'd3, 1'b0, "right_hold");
      end

      // Walk to the left edge and sit there, then to the right edge.
      for (int k = 1; k <= 170; k++) begin
         v = 332 - 2*k;
         if (v < 0) v = 0;
         step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'(v), 10'd440, 1'b1, 2'd3, 1'b0, "walk_left");
      end
      for (int k = 1; k <= 315; k++) begin
         v = 2*k;
         if (v > 624) v = 624;
         step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'(v), 10'd440, 1'b1, 2'd3, 1'b0, "walk_right");
      end
      for (int k = 1; k <= 15; k++) begin
         v = 440 + 2*k;
         if (v > 464) v = 464;
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd624, 10'(v), 1'b1, 2'd3, 1'b0, "walk_down");
      end

      // First hit, ignored second hit, then the 60-frame blink window.
      do_reset("reset_hit");
      ex = 312; ey = 440;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'(ex), 10'(ey), 1'b0, 2'd2, 1'b0, "hit1");
      for (int k = 0; k < 4; k++)
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'(ex), 10'(ey), 1'b0, 2'd2, 1'b0, "hit1_idle");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'(ex), 10'(ey), 1'b0, 2'd2, 1'b0, "hit_ignored");
      for (int k = 1; k <= 60; k++) begin
         if (k <= 5) ex = ex + 2;
         ev = (k == 60) ? 1'b1 : (((k / 4) % 2) == 1);
         step(1'b1, 1'b0, (k <= 5), 1'b0, 1'b0, 1'b0, 1'b0, 10'(ex), 10'(ey), ev, 2'd2, 1'b0, "blink_tick");
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'(ex), 10'(ey), ev, 2'd2, 1'b0, "blink_idle");
      end

      // Second life lost, window, then the last hit coincides with a tick.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'(ex), 10'(ey), 1'b0, 2'd1, 1'b0, "hit2");
      for (int k = 1; k <= 60; k++) begin
         ev = (k == 60) ? 1'b1 : (((k / 4) % 2) == 1);
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'(ex), 10'(ey), ev, 2'd1, 1'b0, "blink2");
      end
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'(ex), 10'(ey), 1'b0, 2'd0, 1'b1, "hit3_dead");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'(ex), 10'(ey), 1'b0, 2'd0, 1'b1, "dead_hit");
      for (int k = 0; k < 5; k++)
         step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'(ex), 10'(ey), 1'b0, 2'd0, 1'b1, "dead_up");

      // Hit and tick together with btn_down: move and life loss on one edge.
      do_reset("reset_combo");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd312, 10'd442, 1'b0, 2'd2, 1'b0, "hit_tick_down");
      for (int k = 1; k <= 30; k++) begin
         ev = ((k / 4) % 2) == 1;
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd312, 10'd442, ev, 2'd2, 1'b0, "hit_frames");
      end
      // Reset wins over a coincident tick and button.
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd312, 10'd440, 1'b1, 2'd3, 1'b0, "reset_mid_hit");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd312, 10'd440, 1'b0, 2'd2, 1'b0, "hit_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
